// File: rtl/div8by4_unsigned_seq.sv
// Sequential unsigned restoring divider, one radix-2 step per clock on a valid/ready stream.
// Optional DIV_ZERO_DETECT_EN: divisor==0 short-circuits to quotient=all ones, div_err=1.
module div8by4_unsigned_seq #(
    parameter int unsigned DW = 8,
    parameter int unsigned VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_err
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e        state;
    logic [DW-1:0] work;   // dividend bits shift out of the top, quotient bits shift in below
    logic [VW:0]   part;
    logic [VW-1:0] dsr;
    logic [CW-1:0] cnt;

    logic [VW:0]   part_shift;
    logic [VW:0]   part_next;
    logic          q_bit;

    always_comb begin
        part_shift = (part << 1) | {{VW{1'b0}}, work[DW-1]};
        q_bit      = (part_shift >= {1'b0, dsr});
        part_next  = q_bit ? (part_shift - {1'b0, dsr}) : part_shift;
    end

`ifdef DIV_ZERO_DETECT_EN
    logic zero;
`else
    assign div_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            work      <= '0;
            part      <= '0;
            dsr       <= '0;
            cnt       <= '0;
`ifdef DIV_ZERO_DETECT_EN
            zero      <= 1'b0;
            div_err   <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        work     <= dividend;
                        dsr      <= divisor;
                        part     <= '0;
                        cnt      <= CW'(DW - 1);
                        in_ready <= 1'b0;
                        state    <= StCalc;
`ifdef DIV_ZERO_DETECT_EN
                        zero     <= (divisor == '0);
`endif
                    end
                end
                StCalc: begin
                    work <= {work[DW-2:0], q_bit};
                    part <= part_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state     <= StDone;
                        out_valid <= 1'b1;
                        quotient  <= {work[DW-2:0], q_bit};
                        remainder <= part_next[VW-1:0];
                    end
`ifdef DIV_ZERO_DETECT_EN
                    // Later assignments override the normal step for a zero divisor
                    div_err <= zero;
                    if (zero) begin
                        state     <= StDone;
                        out_valid <= 1'b1;
                        quotient  <= '1;
                        remainder <= '0;
                    end
`endif
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_div8by4_unsigned_seq.sv
// Scoreboard bench for div8by4_unsigned_seq: expected results queued at accept, popped on
// each output handshake.
module tb_div8by4_unsigned_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_err;

    int checks   = 0;
    int failures = 0;

    logic [12:0] exp_q[$];   // {div_err, quotient, remainder}

    always #5 clk = ~clk;

    div8by4_unsigned_seq #(
        .DW(8),
        .VW(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .remainder(remainder),
        .div_err  (div_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] model(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] q;
        logic [7:0] r;
        if (b == 4'd0) begin
`ifdef DIV_ZERO_DETECT_EN
            return {1'b1, 8'hFF, 4'h0};
`else
            return {1'b0, 8'hFF, a[3:0]};
`endif
        end
        q = a / {4'h0, b};
        r = a % {4'h0, b};
        return {1'b0, q, r[3:0]};
    endfunction

    function automatic int exp_lat(input logic [3:0] b);
`ifdef DIV_ZERO_DETECT_EN
        if (b == 4'd0) return 1;
`endif
        return 8;
    endfunction

    // Scoreboard consumer: one pop per output handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'(out_valid), 32'd0);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                check_eq("quotient", 32'(quotient), 32'(e[11:4]));
                check_eq("remainder", 32'(remainder), 32'(e[3:0]));
                check_eq("div_err", 32'(div_err), 32'(e[12]));
            end
        end
    end

    // Present operands until accepted; optionally record the expected result.
    task automatic send(input logic [7:0] a, input logic [3:0] b, input bit push);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);
        if (push) exp_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = a ^ 8'hA5;   // must be ignored while busy
        divisor  = b ^ 4'h6;
    endtask

    // Returns at the negedge where out_valid is first seen; checks latency in clocks.
    task automatic wait_out(input int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        check_eq("latency", 32'(n), 32'(lat));
        check_eq("in_ready_busy", 32'(in_ready), 32'd0);
    endtask

    task automatic after_handshake();
        @(posedge clk);
        #1;
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);
        check_eq("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic run(input logic [7:0] a, input logic [3:0] b);
        send(a, b, 1'b1);
        wait_out(exp_lat(b));
        after_handshake();
    endtask

    initial begin
        logic [7:0] bb_a[4];
        logic [3:0] bb_b[4];
        logic [7:0] ra;
        logic [3:0] rb;
        bb_a = '{8'd110, 8'd156, 8'd56, 8'd90};
        bb_b = '{4'd11, 4'd13, 4'd8, 4'd10};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_quotient", 32'(quotient), 32'd0);
        check_eq("rst_remainder", 32'(remainder), 32'd0);
        check_eq("rst_div_err", 32'(div_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(8'hD2, 4'hE);
        for (int i = 0; i < 4; i++) run(bb_a[i], bb_b[i]);
        run(8'd255, 4'd7);
        run(8'd255, 4'd1);
        run(8'd0, 4'd9);
        run(8'd3, 4'd15);

        // Backpressure: result and outputs held while out_ready is low
        out_ready = 1'b0;
        send(8'd200, 4'd9, 1'b1);
        wait_out(8);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_quotient", 32'(quotient), 32'd22);
            check_eq("bp_remainder", 32'(remainder), 32'd2);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        after_handshake();

        // Reset in the middle of a calculation discards it
        send(8'hD2, 4'hE, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_quotient", 32'(quotient), 32'd0);
        check_eq("midrst_remainder", 32'(remainder), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_eq("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        run(8'd99, 4'd5);

        run(8'd200, 4'd0);

        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 4'($urandom_range(0, 15));
            run(ra, rb);
        end

        repeat (3) @(negedge clk);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
